// File: rtl/bcd_converter_seq_if.sv
// Handshake and result bundle between the up/down counter (master) and the
// sequential binary-to-BCD converter (slave).
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN adds the per-digit blank
// vector to the bundle and to both modports.
interface bcd_converter_seq_if #(
  parameter int BIT_SIZE = 20,
  parameter int DIGITS   = 6
);

  logic                  start;
  logic [BIT_SIZE-1:0]   number;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, number,
    input  busy, done, overflow, bcd, blank
  );

  modport slave (
    input  start, number,
    output busy, done, overflow, bcd, blank
  );
`else
  modport master (
    output start, number,
    input  busy, done, overflow, bcd
  );

  modport slave (
    input  start, number,
    output busy, done, overflow, bcd
  );
`endif

endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// A binary count is captured on an accepted start, converted over BIT_SIZE
// cycles, and the packed BCD result is published together with a one-cycle
// done pulse. Values above 10^DIGITS-1 saturate to all nines with overflow=1.
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN adds a registered
// leading-zero blank vector, updated on the same edge as bcd.
module bcd_converter_seq #(
  parameter int BIT_SIZE = 20,
  parameter int DIGITS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_converter_seq_if.slave   bus
);

  // Step counter must be able to hold BIT_SIZE itself.
  localparam int CNT_W  = $clog2(BIT_SIZE + 1);
  // Scratch holds DIGITS nibbles plus one carry bit above them.
  localparam int SCR_W  = 4 * DIGITS + 1;
  localparam int STEP_W = SCR_W + BIT_SIZE;
  // Overflow compare is done wide enough to hold 10^8-1 for any input width.
  localparam int CMP_W  = (BIT_SIZE > 34) ? BIT_SIZE : 34;

  // Largest value representable in DIGITS decimal digits.
  function automatic logic [CMP_W-1:0] max_value(input int digits);
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < digits; i++) begin
      p = p * CMP_W'(10);
    end
    return p - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0]      MAX_VAL   = max_value(DIGITS);
  localparam logic [4*DIGITS-1:0]   ALL_NINES = {DIGITS{4'h9}};
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BIT_SIZE - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  state_e                state_q, state_d;

  // Iteration datapath.
  logic [BIT_SIZE-1:0]   bin_q;
  logic [SCR_W-1:0]      scratch_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_pend_q;

  // Published results.
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  ovf_q;
  logic                  done_q;

  // FSM decode.
  logic                  busy_d;
  logic                  load;
  logic                  step;
  logic                  last;
  logic                  cnt_last;

  // One double-dabble iteration.
  logic [STEP_W-1:0]     step_v;
  logic [SCR_W-1:0]      scratch_step;
  logic [BIT_SIZE-1:0]   bin_step;
  logic [4*DIGITS-1:0]   result_d;

  assign cnt_last = (cnt_q == LAST_CNT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE.
  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes.
  always_comb begin
    busy_d = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    case (state_q)
      IDLE: begin
        load = bus.start;
      end
      CONVERT: begin
        busy_d = 1'b1;
        step   = 1'b1;
        last   = cnt_last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // One iteration: add 3 to every digit nibble >= 5, then shift {scratch, bin}
  // left by one. The carry bit above the digits is never adjusted.
  always_comb begin
    step_v = {scratch_q, bin_q};
    for (int i = 0; i < DIGITS; i++) begin
      if (step_v[BIT_SIZE + 4*i +: 4] >= 4'd5) begin
        step_v[BIT_SIZE + 4*i +: 4] = step_v[BIT_SIZE + 4*i +: 4] + 4'd3;
      end
    end
    step_v = step_v << 1;
  end

  assign scratch_step = step_v[STEP_W-1 -: SCR_W];
  assign bin_step     = step_v[BIT_SIZE-1:0];

  // Value published on the final step: saturated digits replace a result
  // that could not fit.
  assign result_d = ovf_pend_q ? ALL_NINES : scratch_step[4*DIGITS-1:0];

  // Capture on accept, iterate while converting; number is ignored after capture.
  // NOTE: the shift, scratch and counter registers are reset too, so an
  // aborted conversion leaves no stale partial digits behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (load) begin
      bin_q      <= bus.number;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= (CMP_W'(bus.number) > MAX_VAL);
    end else if (step) begin
      bin_q      <= bin_step;
      scratch_q  <= scratch_step;
      cnt_q      <= cnt_q + 1'b1;
    end
  end

  // Result registers: change only on the final-step edge; done pulses after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (last) begin
        bcd_q <= result_d;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign bus.busy     = busy_d;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Units digit is never blanked so that zero still shows a single "0".
  localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'({DIGITS{1'b1}} << 1);

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;

  // Blank a digit when it and every more-significant digit are zero.
  // Saturated nines are non-zero, so overflow naturally yields no blanking.
  always_comb begin
    logic zero_above;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (result_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  // Blank vector is registered on the same edge as bcd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= BLANK_RST;
    end else if (last) begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Self-checking bench for bcd_converter_seq: a default-size instance
// (20-bit, 6 digits) and a small instance (10-bit, 3 digits), compared
// against an arithmetic decimal model (divide/modulo by ten).
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN also checks blank.
module tb_bcd_converter_seq;

  localparam int BS   = 20;
  localparam int DG   = 6;
  localparam int BS_S = 10;
  localparam int DG_S = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bcd_converter_seq_if #(.BIT_SIZE(BS),   .DIGITS(DG))   bus_l ();
  bcd_converter_seq_if #(.BIT_SIZE(BS_S), .DIGITS(DG_S)) bus_s ();

  bcd_converter_seq #(.BIT_SIZE(BS), .DIGITS(DG)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  bcd_converter_seq #(.BIT_SIZE(BS_S), .DIGITS(DG_S)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint unsigned pow10(input int d);
    longint unsigned r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit ref_ovf(input longint unsigned n, input int d);
    return n >= pow10(d);
  endfunction

  function automatic logic [31:0] ref_bcd(input longint unsigned n, input int d);
    logic [31:0]     r = '0;
    longint unsigned v = n;
    if (ref_ovf(n, d)) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
    end else begin
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  // Digit i (i >= 1) is blank when the value has fewer than i+1 digits.
  function automatic logic [7:0] ref_blank(input longint unsigned n, input int d);
    logic [7:0] r = '0;
    if (!ref_ovf(n, d)) begin
      for (int i = 1; i < d; i++) r[i] = (n < pow10(i));
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge with the DUT idle, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic run_big(input logic [BS-1:0] n, output int lat, output int n_done,
                         output int busy_cyc, output bit glitch,
                         output logic [4*DG-1:0] bcd_r, output logic ovf_r);
    logic [4*DG-1:0] prev_bcd;
    logic            prev_ovf;
    lat = -1; n_done = 0; busy_cyc = 0; glitch = 1'b0;
    bcd_r = 'x; ovf_r = 1'bx;
    prev_bcd = bus_l.bcd;
    prev_ovf = bus_l.overflow;
    bus_l.number = n;
    bus_l.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < BS + 6; k++) begin
      @(negedge clk);
      if (k == 0) bus_l.start = 1'b0;
      if (bus_l.busy) busy_cyc++;
      if (bus_l.done) begin
        n_done++;
        if (lat < 0) lat = k;
        bcd_r = bus_l.bcd;
        ovf_r = bus_l.overflow;
        prev_bcd = bus_l.bcd;
        prev_ovf = bus_l.overflow;
      end else if (bus_l.bcd !== prev_bcd || bus_l.overflow !== prev_ovf) begin
        glitch = 1'b1;
      end
    end
  endtask

  task automatic run_small(input logic [BS_S-1:0] n, output int lat, output int n_done,
                           output logic [4*DG_S-1:0] bcd_r, output logic ovf_r);
    lat = -1; n_done = 0; bcd_r = 'x; ovf_r = 1'bx;
    bus_s.number = n;
    bus_s.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < BS_S + 6; k++) begin
      @(negedge clk);
      if (k == 0) bus_s.start = 1'b0;
      if (bus_s.done) begin
        n_done++;
        if (lat < 0) lat = k;
        bcd_r = bus_s.bcd;
        ovf_r = bus_s.overflow;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if (bus_l.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_l.busy); else pass_cnt++;
    total_cnt++; if (bus_l.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_l.done); else pass_cnt++;
    total_cnt++; if (bus_l.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", bus_l.overflow); else pass_cnt++;
    total_cnt++; if (bus_l.bcd !== '0) $display("FAIL reset_bcd: got %h expected 0", bus_l.bcd); else pass_cnt++;
    total_cnt++; if (bus_s.bcd !== '0 || bus_s.busy !== 1'b0) $display("FAIL reset_small: bcd %h busy %b expected 0/0", bus_s.bcd, bus_s.busy); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    total_cnt++; if (bus_l.blank !== 6'b111110) $display("FAIL reset_blank: got %b expected 111110", bus_l.blank); else pass_cnt++;
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, n_done, busy_cyc; bit glitch;
    logic [4*DG-1:0] b; logic o;
    run_big(20'd123456, lat, n_done, busy_cyc, glitch, b, o);
    total_cnt++; if (busy_cyc !== BS) $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cyc, BS); else pass_cnt++;
    total_cnt++; if (lat !== BS) $display("FAIL basic_latency: got %0d expected %0d", lat, BS); else pass_cnt++;
    total_cnt++; if (n_done !== 1) $display("FAIL basic_done_count: got %0d expected 1", n_done); else pass_cnt++;
    total_cnt++; if (b !== 24'h123456) $display("FAIL basic_bcd: got %h expected 123456", b); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL basic_overflow: got %b expected 0", o); else pass_cnt++;
    total_cnt++; if (glitch !== 1'b0) $display("FAIL basic_stable: bcd changed away from the final edge"); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    total_cnt++; if (bus_l.blank !== 6'b000000) $display("FAIL basic_blank: got %b expected 000000", bus_l.blank); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    int first_k = -1, second_k = -1;
    logic [4*DG-1:0] bcd_a = 'x, bcd_b = 'x;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DG-1:0] blank_a = 'x, blank_b = 'x;
`endif
    bus_l.number = 20'd0;
    bus_l.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2*BS + 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_l.start = 1'b0;
      if (bus_l.done) begin
        if (first_k < 0) begin
          first_k = k;
          bcd_a = bus_l.bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_a = bus_l.blank;
`endif
          // start held high during the done cycle
          bus_l.number = 20'd999999;
          bus_l.start  = 1'b1;
        end else if (second_k < 0) begin
          second_k = k;
          bcd_b = bus_l.bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_b = bus_l.blank;
`endif
        end
      end else if (first_k >= 0 && k == first_k + 1) begin
        bus_l.start = 1'b0;
      end
    end
    total_cnt++; if (bcd_a !== 24'h000000) $display("FAIL b2b_first_bcd: got %h expected 000000", bcd_a); else pass_cnt++;
    total_cnt++; if (bcd_b !== 24'h999999) $display("FAIL b2b_second_bcd: got %h expected 999999", bcd_b); else pass_cnt++;
    total_cnt++; if (first_k !== BS) $display("FAIL b2b_first_latency: got %0d expected %0d", first_k, BS); else pass_cnt++;
    // The accept edge is the one closing the done cycle, so the next done is BS edges after it.
    total_cnt++; if (second_k !== first_k + BS + 1) $display("FAIL b2b_second_done: got %0d expected %0d", second_k, first_k + BS + 1); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    total_cnt++; if (blank_a !== 6'b111110) $display("FAIL b2b_blank_zero: got %b expected 111110", blank_a); else pass_cnt++;
    total_cnt++; if (blank_b !== 6'b000000) $display("FAIL b2b_blank_nines: got %b expected 000000", blank_b); else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    int lat, n_done, busy_cyc; bit glitch;
    logic [4*DG-1:0] b; logic o;
    run_big(20'd1048575, lat, n_done, busy_cyc, glitch, b, o);
    total_cnt++; if (b !== 24'h999999) $display("FAIL ovf_bcd: got %h expected 999999", b); else pass_cnt++;
    total_cnt++; if (o !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", o); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    total_cnt++; if (bus_l.blank !== 6'b000000) $display("FAIL ovf_blank: got %b expected 000000", bus_l.blank); else pass_cnt++;
`endif
    run_big(20'd1000000, lat, n_done, busy_cyc, glitch, b, o);
    total_cnt++; if (b !== 24'h999999 || o !== 1'b1) $display("FAIL ovf_edge: got %h/%b expected 999999/1", b, o); else pass_cnt++;
    run_big(20'd42, lat, n_done, busy_cyc, glitch, b, o);
    total_cnt++; if (b !== 24'h000042) $display("FAIL ovf_after_bcd: got %h expected 000042", b); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL ovf_after_flag: got %b expected 0", o); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    total_cnt++; if (bus_l.blank !== 6'b111100) $display("FAIL ovf_after_blank: got %b expected 111100", bus_l.blank); else pass_cnt++;
`endif
  endtask

  task automatic test_ignore_start();
    int n_done = 0, lat = -1;
    logic [4*DG-1:0] b = 'x;
    bus_l.number = 20'd500;
    bus_l.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < BS + 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_l.start = 1'b0;
      if (k == 4) begin bus_l.start = 1'b1; bus_l.number = 20'd777; end
      if (k == 5) bus_l.start = 1'b0;
      if (k == 9) bus_l.start = 1'b1;
      if (k == 10) bus_l.start = 1'b0;
      if (bus_l.done) begin
        n_done++;
        if (lat < 0) lat = k;
        b = bus_l.bcd;
      end
    end
    total_cnt++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d expected 1", n_done); else pass_cnt++;
    total_cnt++; if (lat !== BS) $display("FAIL ignore_latency: got %0d expected %0d", lat, BS); else pass_cnt++;
    total_cnt++; if (b !== 24'h000500) $display("FAIL ignore_bcd: got %h expected 000500", b); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, n_done, busy_cyc, stray = 0; bit glitch;
    logic [4*DG-1:0] b; logic o;
    bus_l.number = 20'd654321;
    bus_l.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_l.start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (bus_l.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus_l.busy); else pass_cnt++;
    total_cnt++; if (bus_l.done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", bus_l.done); else pass_cnt++;
    total_cnt++; if (bus_l.bcd !== '0) $display("FAIL rstmid_bcd: got %h expected 0", bus_l.bcd); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < BS + 6; k++) begin
      @(negedge clk);
      if (bus_l.done) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", stray); else pass_cnt++;
    run_big(20'd654321, lat, n_done, busy_cyc, glitch, b, o);
    total_cnt++; if (b !== 24'h654321 || n_done !== 1) $display("FAIL rstmid_rerun: got %h/%0d expected 654321/1", b, n_done); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, n_done, busy_cyc; bit glitch;
    logic [4*DG-1:0] b; logic o;
    logic [BS-1:0]   n;
    logic [31:0]     eb;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) n = BS'($urandom_range(1000000, 1048575));
      else            n = BS'($urandom_range(0, 999999));
      run_big(n, lat, n_done, busy_cyc, glitch, b, o);
      eb = ref_bcd(longint'(n), DG);
      total_cnt++; if (b !== eb[4*DG-1:0]) $display("FAIL rand_bcd n=%0d: got %h expected %h", n, b, eb[4*DG-1:0]); else pass_cnt++;
      total_cnt++; if (o !== ref_ovf(longint'(n), DG)) $display("FAIL rand_ovf n=%0d: got %b expected %b", n, o, ref_ovf(longint'(n), DG)); else pass_cnt++;
      total_cnt++; if (lat !== BS || n_done !== 1 || glitch !== 1'b0) $display("FAIL rand_timing n=%0d: lat %0d dones %0d glitch %b expected %0d/1/0", n, lat, n_done, glitch, BS); else pass_cnt++;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      begin
        logic [7:0] ebl;
        ebl = ref_blank(longint'(n), DG);
        total_cnt++; if (bus_l.blank !== ebl[DG-1:0]) $display("FAIL rand_blank n=%0d: got %b expected %b", n, bus_l.blank, ebl[DG-1:0]); else pass_cnt++;
      end
`endif
    end
  endtask

  task automatic test_small();
    int lat, n_done;
    logic [4*DG_S-1:0] b; logic o;
    logic [BS_S-1:0]   n;
    logic [31:0]       eb;
    run_small(10'd1023, lat, n_done, b, o);
    total_cnt++; if (lat !== BS_S || n_done !== 1) $display("FAIL small_timing: lat %0d dones %0d expected %0d/1", lat, n_done, BS_S); else pass_cnt++;
    total_cnt++; if (b !== 12'h999 || o !== 1'b1) $display("FAIL small_ovf: got %h/%b expected 999/1", b, o); else pass_cnt++;
    run_small(10'd999, lat, n_done, b, o);
    total_cnt++; if (b !== 12'h999 || o !== 1'b0) $display("FAIL small_max: got %h/%b expected 999/0", b, o); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      n = BS_S'($urandom_range(0, 1023));
      run_small(n, lat, n_done, b, o);
      eb = ref_bcd(longint'(n), DG_S);
      total_cnt++; if (b !== eb[4*DG_S-1:0] || o !== ref_ovf(longint'(n), DG_S)) $display("FAIL small_rand n=%0d: got %h/%b expected %h/%b", n, b, o, eb[4*DG_S-1:0], ref_ovf(longint'(n), DG_S)); else pass_cnt++;
    end
  endtask

  initial begin
    bus_l.start  = 1'b0;
    bus_l.number = '0;
    bus_s.start  = 1'b0;
    bus_s.number = '0;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
